// File: rtl/spi_frame_pkg.sv
// Shared defaults and the state enumeration for the SPI frame scheduler.
package spi_frame_pkg;
   localparam int unsigned FRAME_BYTES_DEF = 15;
   localparam int unsigned ADDR_W_DEF      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2,
      DRAIN = 2'd3
   } state_e;
endpackage

// File: rtl/spi_frame_sched_if.sv
// Bus between the frame scheduler and its SPI receiver / buffer / consumers.
interface spi_frame_sched_if
   import spi_frame_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
);
   logic              start;
   logic              byte_valid;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              spi_cs;
   logic              frame_ready;
   logic              frame_done;
   logic              ovf;

   modport master (
      output start, byte_valid, req,
      input  wr_en, wr_addr, rd_en, rd_addr, gnt, spi_cs, frame_ready, frame_done, ovf
   );

   modport slave (
      input  start, byte_valid, req,
      output wr_en, wr_addr, rd_en, rd_addr, gnt, spi_cs, frame_ready, frame_done, ovf
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the grant is combinational, the
// last-winner memory advances only when update is pulsed.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gnt
);
   // 1 when requester 1 won last, which hands the next tie to requester 0
   logic last_q;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_q ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         last_q <= 1'b1;
      end else if (update && (gnt != 2'b00)) begin
         last_q <= gnt[1];
      end
   end
endmodule

// File: rtl/spi_frame_sched.sv
// Frame buffer scheduler: fills one frame from SPI bytes, then drains it
// to a single round-robin-selected consumer.
module spi_frame_sched
   import spi_frame_pkg::*;
#(
   parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF,
   parameter int unsigned ADDR_W      = ADDR_W_DEF
) (
   input logic              clk,
   input logic              rst,
   spi_frame_sched_if.slave bus
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              wr_en_q, wr_en_d;
   logic              rd_en_q, rd_en_d;
   logic [1:0]        gnt_q, gnt_d;
   logic              spi_cs_q, spi_cs_d;
   logic              frame_ready_q, frame_ready_d;
   logic              frame_done_q, frame_done_d;
   logic              ovf_q, ovf_d;
   logic [1:0]        arb_gnt;
   logic              arb_update;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (bus.req),
      .update (arb_update),
      .gnt    (arb_gnt)
   );

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         wr_addr_q     <= '0;
         rd_addr_q     <= '0;
         wr_en_q       <= 1'b0;
         rd_en_q       <= 1'b0;
         gnt_q         <= 2'b00;
         spi_cs_q      <= 1'b0;
         frame_ready_q <= 1'b0;
         frame_done_q  <= 1'b0;
         ovf_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wr_addr_q     <= wr_addr_d;
         rd_addr_q     <= rd_addr_d;
         wr_en_q       <= wr_en_d;
         rd_en_q       <= rd_en_d;
         gnt_q         <= gnt_d;
         spi_cs_q      <= spi_cs_d;
         frame_ready_q <= frame_ready_d;
         frame_done_q  <= frame_done_d;
         ovf_q         <= ovf_d;
      end
   end

   // Next state and next output values; DRAIN lasts exactly as long as rd_en is high
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      wr_addr_d     = wr_addr_q;
      rd_addr_d     = rd_addr_q;
      wr_en_d       = 1'b0;
      rd_en_d       = 1'b0;
      gnt_d         = gnt_q;
      spi_cs_d      = 1'b0;
      frame_ready_d = 1'b0;
      frame_done_d  = 1'b0;
      ovf_d         = ovf_q;
      arb_update    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.byte_valid) ovf_d = 1'b1;
            if (bus.start) begin
               state_d  = FILL;
               cnt_d    = '0;
               spi_cs_d = 1'b1;
            end
         end
         FILL: begin
            spi_cs_d = 1'b1;
            if (bus.byte_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q;
               if (cnt_q == LAST_ADDR) begin
                  state_d       = FULL;
                  cnt_d         = '0;
                  spi_cs_d      = 1'b0;
                  frame_ready_d = 1'b1;
               end else begin
                  cnt_d = ADDR_W'(cnt_q + 1'b1);
               end
            end
         end
         FULL: begin
            if (bus.byte_valid) ovf_d = 1'b1;
            frame_ready_d = 1'b1;
            if (bus.req != 2'b00) begin
               state_d       = DRAIN;
               frame_ready_d = 1'b0;
               rd_en_d       = 1'b1;
               rd_addr_d     = '0;
               gnt_d         = arb_gnt;
               arb_update    = 1'b1;
            end
         end
         DRAIN: begin
            if (bus.byte_valid) ovf_d = 1'b1;
            if (rd_addr_q == LAST_ADDR) begin
               state_d      = IDLE;
               gnt_d        = 2'b00;
               frame_done_d = 1'b1;
            end else begin
               rd_en_d   = 1'b1;
               rd_addr_d = ADDR_W'(rd_addr_q + 1'b1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.wr_en       = wr_en_q;
   assign bus.wr_addr     = wr_addr_q;
   assign bus.rd_en       = rd_en_q;
   assign bus.rd_addr     = rd_addr_q;
   assign bus.gnt         = gnt_q;
   assign bus.spi_cs      = spi_cs_q;
   assign bus.frame_ready = frame_ready_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_spi_frame_sched.sv
// Self-checking bench for spi_frame_sched: randomized gaps, requests and drop
// points checked against a frame-level model of fill, drain and fairness.
module tb_spi_frame_sched;
   import spi_frame_pkg::*;

   localparam int unsigned FB = 15;
   localparam int unsigned AW = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   prio   = 0;     // requester that wins the next tie
   logic exp_ovf = 1'b0;

   always #5 clk = ~clk;

   spi_frame_sched_if #(.ADDR_W(AW)) bus ();

   spi_frame_sched #(.FRAME_BYTES(FB), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] model_grant(input logic [1:0] r, input int p);
      if (r == 2'b11) return (p == 0) ? 2'b01 : 2'b10;
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b0; bus.start = 1'b0; bus.byte_valid = 1'b0; bus.req = 2'b00;
      step(); step();
      checks++;
      if ({bus.wr_en, bus.rd_en, bus.gnt, bus.spi_cs, bus.frame_ready, bus.frame_done,
           bus.ovf, bus.wr_addr, bus.rd_addr} !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs: got wr_en=%b rd_en=%b gnt=%b cs=%b rdy=%b done=%b ovf=%b wa=%0d ra=%0d want all 0",
                  bus.wr_en, bus.rd_en, bus.gnt, bus.spi_cs, bus.frame_ready, bus.frame_done,
                  bus.ovf, bus.wr_addr, bus.rd_addr);
      end
      checks++;
      if (dut.state_q !== IDLE) begin
         errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
      end
      rst = 1'b1; prio = 0; exp_ovf = 1'b0;
   endtask

   // Fill one frame; random idle gaps (with ignored start pulses) between bytes
   task automatic fill_frame(input int maxgap);
      bus.start = 1'b1; step(); bus.start = 1'b0;
      checks++;
      if (bus.spi_cs !== 1'b1 || bus.wr_en !== 1'b0) begin
         errors++; $display("FAIL fill_start: got cs=%b wr_en=%b want cs=1 wr_en=0", bus.spi_cs, bus.wr_en);
      end
      for (int k = 0; k < int'(FB); k++) begin
         int gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
         for (int g = 0; g < gap; g++) begin
            bus.start = 1'($urandom % 2);
            step();
            bus.start = 1'b0;
            checks++;
            if (bus.wr_en !== 1'b0 || bus.spi_cs !== 1'b1) begin
               errors++; $display("FAIL fill_gap: got wr_en=%b cs=%b want wr_en=0 cs=1", bus.wr_en, bus.spi_cs);
            end
         end
         bus.byte_valid = 1'b1; step(); bus.byte_valid = 1'b0;
         checks++;
         if (bus.wr_en !== 1'b1 || bus.wr_addr !== AW'(k) || bus.rd_en !== 1'b0) begin
            errors++; $display("FAIL fill_write: got wr_en=%b wr_addr=%0d rd_en=%b want 1 %0d 0",
                               bus.wr_en, bus.wr_addr, bus.rd_en, k);
         end
         checks++;
         if (k == int'(FB) - 1) begin
            if (bus.frame_ready !== 1'b1 || bus.spi_cs !== 1'b0) begin
               errors++; $display("FAIL fill_full: got rdy=%b cs=%b want rdy=1 cs=0", bus.frame_ready, bus.spi_cs);
            end
         end else if (bus.frame_ready !== 1'b0 || bus.spi_cs !== 1'b1) begin
            errors++; $display("FAIL fill_busy: got rdy=%b cs=%b want rdy=0 cs=1", bus.frame_ready, bus.spi_cs);
         end
      end
      checks++;
      if (bus.ovf !== exp_ovf) begin
         errors++; $display("FAIL fill_ovf: got %b want %b", bus.ovf, exp_ovf);
      end
   endtask

   // Drain a full frame; req is dropped after read drop_at (negative: never)
   task automatic drain_frame(input logic [1:0] r, input int drop_at);
      logic [1:0] exp_g;
      int wait_cyc = int'($urandom_range(0, 2));
      for (int w = 0; w < wait_cyc; w++) begin
         step();
         checks++;
         if (bus.frame_ready !== 1'b1 || bus.rd_en !== 1'b0 || bus.gnt !== 2'b00) begin
            errors++; $display("FAIL full_wait: got rdy=%b rd_en=%b gnt=%b want 1 0 00",
                               bus.frame_ready, bus.rd_en, bus.gnt);
         end
      end
      exp_g = model_grant(r, prio);
      prio  = (exp_g == 2'b01) ? 1 : 0;
      bus.req = r;
      step();
      for (int i = 0; i < int'(FB); i++) begin
         checks++;
         if (bus.rd_en !== 1'b1 || bus.wr_en !== 1'b0 || bus.gnt !== exp_g || bus.rd_addr !== AW'(i)) begin
            errors++; $display("FAIL drain_read: got rd_en=%b wr_en=%b gnt=%b rd_addr=%0d want 1 0 %b %0d",
                               bus.rd_en, bus.wr_en, bus.gnt, bus.rd_addr, exp_g, i);
         end
         if (i == drop_at) bus.req = 2'b00;
         step();
      end
      checks++;
      if (bus.rd_en !== 1'b0 || bus.gnt !== 2'b00 || bus.frame_ready !== 1'b0 || bus.frame_done !== 1'b1) begin
         errors++; $display("FAIL drain_done: got rd_en=%b gnt=%b rdy=%b done=%b want 0 00 0 1",
                            bus.rd_en, bus.gnt, bus.frame_ready, bus.frame_done);
      end
      checks++;
      if (dut.state_q !== IDLE || bus.ovf !== exp_ovf) begin
         errors++; $display("FAIL drain_idle: got state=%0d ovf=%b want IDLE ovf=%b", dut.state_q, bus.ovf, exp_ovf);
      end
      bus.req = 2'b00;
      step();
      checks++;
      if (bus.frame_done !== 1'b0 || bus.rd_en !== 1'b0) begin
         errors++; $display("FAIL done_pulse: got done=%b rd_en=%b want 0 0", bus.frame_done, bus.rd_en);
      end
   endtask

   task automatic test_idle_overrun();
      bus.byte_valid = 1'b1; step(); bus.byte_valid = 1'b0;
      checks++;
      if (bus.wr_en !== 1'b0 || bus.ovf !== 1'b1 || bus.spi_cs !== 1'b0) begin
         errors++; $display("FAIL idle_ovf: got wr_en=%b ovf=%b cs=%b want 0 1 0", bus.wr_en, bus.ovf, bus.spi_cs);
      end
      step();
      checks++;
      if (bus.ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky: got %b want 1", bus.ovf);
      end
      test_reset();
   endtask

   task automatic test_basic_fill_drain();
      fill_frame(0);
      drain_frame(2'b01, -1);
   endtask

   task automatic test_fairness();
      test_reset();
      for (int f = 0; f < 3; f++) begin
         fill_frame(1);
         drain_frame(2'b11, -1);
      end
   endtask

   task automatic test_overrun();
      fill_frame(0);
      bus.byte_valid = 1'b1; step(); bus.byte_valid = 1'b0;
      exp_ovf = 1'b1;
      checks++;
      if (bus.wr_en !== 1'b0 || bus.ovf !== 1'b1 || bus.frame_ready !== 1'b1) begin
         errors++; $display("FAIL full_ovf: got wr_en=%b ovf=%b rdy=%b want 0 1 1", bus.wr_en, bus.ovf, bus.frame_ready);
      end
      drain_frame(2'b10, -1);
      fill_frame(2);
      drain_frame(2'b01, -1);
   endtask

   task automatic test_reset_mid_drain();
      fill_frame(0);
      bus.req = 2'b01;
      step();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (bus.rd_en !== 1'b1 || bus.rd_addr !== AW'(i)) begin
            errors++; $display("FAIL pre_reset_read: got rd_en=%b rd_addr=%0d want 1 %0d", bus.rd_en, bus.rd_addr, i);
         end
         if (i < 7) step();
      end
      rst = 1'b0; step();
      checks++;
      if ({bus.wr_en, bus.rd_en, bus.gnt, bus.spi_cs, bus.frame_ready, bus.frame_done, bus.ovf} !== 8'h0
          || dut.state_q !== IDLE) begin
         errors++; $display("FAIL mid_drain_reset: got wr_en=%b rd_en=%b gnt=%b cs=%b state=%0d want zeros IDLE",
                            bus.wr_en, bus.rd_en, bus.gnt, bus.spi_cs, dut.state_q);
      end
      rst = 1'b1; bus.req = 2'b00; prio = 0; exp_ovf = 1'b0;
      step();
      checks++;
      if (bus.rd_en !== 1'b0 || bus.gnt !== 2'b00) begin
         errors++; $display("FAIL post_reset_quiet: got rd_en=%b gnt=%b want 0 00", bus.rd_en, bus.gnt);
      end
      fill_frame(0);
      drain_frame(2'b11, -1);
   endtask

   task automatic test_gapped_abort();
      for (int f = 0; f < 3; f++) begin
         logic [1:0] r = 2'($urandom_range(1, 3));
         fill_frame(3);
         drain_frame(r, int'($urandom_range(0, 13)));
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.byte_valid = 1'b0; bus.req = 2'b00; rst = 1'b0;
      test_reset();
      test_idle_overrun();
      test_basic_fill_drain();
      test_fairness();
      test_overrun();
      test_reset_mid_drain();
      test_gapped_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_frame_sched.md
SPI_FRAME_SCHED -- requirements
Module: spi_frame_sched

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 15: number of bytes per frame buffer.
REQ-002 SHALL have parameter ADDR_W, default 4: width of the buffer byte address.
REQ-003 SHALL have input clk, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have input rst, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have input start, 1 bit: one-cycle pulse that begins a frame fill.
REQ-006 SHALL have input byte_valid, 1 bit: one received SPI byte is present on the write datapath.
REQ-007 SHALL have outputs wr_en (1 bit) and wr_addr (ADDR_W bits): buffer write strobe and address.
REQ-008 SHALL have outputs rd_en (1 bit) and rd_addr (ADDR_W bits): buffer read strobe and address.
REQ-009 SHALL have inputs req[1:0] and outputs gnt[1:0]: per-consumer drain request and one-hot grant.
REQ-010 SHALL have output spi_cs, 1 bit: active-high, asserted while filling.
REQ-011 SHALL have output frame_ready, 1 bit: frame is full and awaiting a consumer.
REQ-012 SHALL have output frame_done, 1 bit: one-cycle pulse after the last drain read.
REQ-013 SHALL have output ovf, 1 bit: sticky overrun flag.

Function
REQ-014 SHALL implement the states IDLE, FILL, FULL and DRAIN, with all outputs registered.
REQ-015 In IDLE, a start pulse SHALL move the block to FILL and clear the byte counter to 0; in all other states start SHALL be ignored.
REQ-016 In FILL, spi_cs SHALL be 1.
REQ-017 In FILL, byte_valid at cycle N SHALL produce wr_en=1 at N+1, with wr_addr equal to the byte count before the increment.
REQ-018 When the FRAME_BYTES-th byte is accepted at cycle N, the block SHALL be in FULL at N+1 with frame_ready=1 and spi_cs=0.
REQ-019 In FULL, if any req bit is 1 at cycle N, then at N+1: state SHALL be DRAIN, exactly one gnt bit SHALL be set, rd_en=1 and rd_addr=0.
REQ-020 Arbitration SHALL be round-robin: with both requests set, the requester not granted last wins; after reset, req[0] wins the first tie.
REQ-021 In DRAIN, rd_en SHALL stay 1 for exactly FRAME_BYTES consecutive cycles, with rd_addr stepping 0..FRAME_BYTES-1, and gnt SHALL be held for those same cycles.
REQ-022 Deasserting the granted req during DRAIN SHALL NOT abort the drain.
REQ-023 The cycle after the last read, gnt SHALL be 0, frame_ready SHALL be 0, frame_done SHALL be 1 for one cycle, and the state SHALL be IDLE.
REQ-024 byte_valid in IDLE, FULL or DRAIN SHALL NOT assert wr_en and SHALL set ovf=1; ovf SHALL be cleared only by reset.
REQ-025 byte_valid in IDLE SHALL also set ovf.
REQ-026 Address counters SHALL never exceed FRAME_BYTES-1; no wrap-around write SHALL ever occur.
REQ-027 wr_en and rd_en SHALL never both be 1 in the same cycle.

Reset
REQ-028 With rst=0 sampled on a clk edge, the block SHALL go to IDLE and clear all counters.
REQ-029 On reset, wr_en, rd_en, gnt, spi_cs, frame_ready, frame_done and ovf SHALL be 0, and wr_addr and rd_addr SHALL be 0.
REQ-030 On reset, the round-robin pointer SHALL be set so that req[0] has priority.
REQ-031 Reset during FILL or DRAIN SHALL abandon the frame with no further strobes.

Structure
REQ-032 Package spi_frame_pkg SHALL hold the FRAME_BYTES and ADDR_W defaults and the state enumeration (IDLE, FILL, FULL, DRAIN).
REQ-033 The round-robin logic SHALL be a sub-module rr_arb2 (inputs req[1:0] and update; output one-hot gnt; internal last-grant register).

Verification
REQ-034 Basic fill: reset, start, then 15 byte_valid on consecutive cycles -> wr_addr 0..14 each one cycle after its byte; frame_ready=1 one cycle after byte 15; spi_cs=1 only during FILL.
REQ-035 Single drain: req=2'b01 in FULL -> gnt=2'b01 and rd_en high for 15 cycles with rd_addr 0..14, then frame_done one pulse and IDLE.
REQ-036 Fairness: req=2'b11 held across three frames -> grants 01, 10, 01.
REQ-037 Overrun: 16th byte_valid arriving in FULL -> no wr_en, ovf=1 and ovf stays 1 through the next frame.
REQ-038 Reset mid-drain: rst=0 at rd_addr=7 -> next cycle all strobes and gnt are 0 and the state is IDLE; a new start performs a clean fill.
REQ-039 Gapped input and abort attempt: byte_valid with random gaps and req dropped mid-drain -> addresses stay contiguous and the drain completes all 15 reads.
